// File: rtl/mult_ctrl.sv
// mult_ctrl: job sequencer for the 1-D multiplier-switch array.
// Per job: one stationary fetch, N streaming fetches, a fixed drain
// interval for the array pipeline, then a one-cycle completion pulse.
module mult_ctrl #(
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_num_stream,
    input  logic                 i_abort,
    input  logic                 i_fetch_ready,
    output logic                 o_fetch,
    output logic                 o_mult_valid,
    output logic                 o_mult_stationary,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_stream_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Drain counter starts one below the interval so the DRAIN state lasts
    // exactly DRAIN_CYCLES cycles including its entry cycle.
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] remaining;
    logic [CNT_WIDTH-1:0] stream_cnt;
    logic [7:0]           drain_cnt;
    logic                 fetch;

    // A pop happens only when the buffer head is valid and no abort is
    // pending, so the buffer and the array always see the same beat.
    assign fetch             = ((state == LOAD) || (state == STREAM)) && i_fetch_ready && !i_abort;
    assign o_fetch           = fetch;
    assign o_mult_valid      = fetch;
    assign o_mult_stationary = (state == LOAD) && fetch;
    assign o_busy            = (state != IDLE);
    assign o_done            = (state == DONE) && !i_abort;
    assign o_stream_cnt      = stream_cnt;

    // Job sequencing; abort outranks every transition except from IDLE,
    // where it is a no-op and a start still proceeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            stream_cnt <= '0;
            drain_cnt  <= '0;
        end else if (i_abort && (state != IDLE)) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        remaining  <= i_num_stream;
                        stream_cnt <= '0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (fetch) begin
                        if (remaining != '0) begin
                            state <= STREAM;
                        end else begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end
                    end
                end
                STREAM: begin
                    if (fetch) begin
                        remaining  <= remaining - CNT_WIDTH'(1);
                        stream_cnt <= stream_cnt + CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 8'd0) state <= DONE;
                    else                   drain_cnt <= drain_cnt - 8'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed timing checks plus randomized traffic, all compared
// every cycle against a job-level behavioural model.
module tb_mult_ctrl;

    localparam int CW = 16;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] i_num_stream = '0;
    logic          i_abort = 1'b0;
    logic          i_fetch_ready = 1'b0;
    logic          o_fetch, o_mult_valid, o_mult_stationary, o_busy, o_done;
    logic [CW-1:0] o_stream_cnt;

    mult_ctrl #(.CNT_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_num_stream(i_num_stream),
        .i_abort(i_abort), .i_fetch_ready(i_fetch_ready), .o_fetch(o_fetch),
        .o_mult_valid(o_mult_valid), .o_mult_stationary(o_mult_stationary),
        .o_busy(o_busy), .o_done(o_done), .o_stream_cnt(o_stream_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Job model: a job owes one stationary beat, then m_left stream beats,
    // then m_drain idle cycles, then one completion cycle.
    bit      m_busy, m_stat, m_fin;
    int      m_left, m_drain;
    int      m_cnt;

    // Event log for the literal timing checks of directed jobs.
    int cyc, done_at, stat_at, vld_n;

    task automatic chk(string name, longint act, longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_stat = 0; m_fin = 0; m_left = 0; m_drain = 0; m_cnt = 0;
    endtask

    task automatic clr_log();
        cyc = 0; done_at = -1; stat_at = -1; vld_n = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs at the falling edge,
    // advance the model, then step past the rising edge.
    task automatic cycle(bit s, int n, bit ab, bit rd);
        bit ef, es, ed;
        i_start = s; i_num_stream = CW'(n); i_abort = ab; i_fetch_ready = rd;
        @(negedge clk);
        ef = m_busy && (m_stat || m_left > 0) && rd && !ab;
        es = ef && m_stat;
        ed = m_fin && !ab;
        chk("fetch",      o_fetch,           ef);
        chk("valid",      o_mult_valid,      ef);
        chk("stationary", o_mult_stationary, es);
        chk("busy",       o_busy,            m_busy);
        chk("done",       o_done,            ed);
        chk("stream_cnt", o_stream_cnt,      m_cnt);
        if (o_done) done_at = cyc;
        if (o_mult_stationary) stat_at = cyc;
        if (o_mult_valid && !o_mult_stationary) vld_n++;
        if (m_busy && ab) begin
            m_busy = 0; m_stat = 0; m_fin = 0; m_left = 0; m_drain = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1; m_stat = 1; m_left = n; m_cnt = 0;
            end
        end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
        end else if (m_stat || m_left > 0) begin
            if (ef) begin
                if (m_stat) m_stat = 0;
                else begin m_left--; m_cnt = (m_cnt + 1) % 65536; end
                if (!m_stat && m_left == 0) m_drain = DC;
            end
        end else begin
            m_drain--;
            if (m_drain == 0) m_fin = 1;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle_run(int k);
        for (int i = 0; i < k; i++) cycle(0, 0, 0, 1);
    endtask

    initial begin
        model_reset();
        clr_log();
        #2;
        chk("reset_fetch", o_fetch, 0);
        chk("reset_stat",  o_mult_stationary, 0);
        chk("reset_busy",  o_busy, 0);
        chk("reset_done",  o_done, 0);
        chk("reset_cnt",   o_stream_cnt, 0);
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;

        // Basic job N=4
        clr_log();
        cycle(1, 4, 0, 1);
        idle_run(11);
        chk("basic_stat_at", stat_at, 1);
        chk("basic_beats",   vld_n, 4);
        chk("basic_done_at", done_at, 9);
        chk("basic_cnt",     o_stream_cnt, 4);

        // Stalls at cycles 1 and 3, N=3
        clr_log();
        cycle(1, 3, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        idle_run(9);
        chk("stall_stat_at", stat_at, 2);
        chk("stall_beats",   vld_n, 3);
        chk("stall_done_at", done_at, 10);

        // Zero-length job
        clr_log();
        cycle(1, 0, 0, 1);
        idle_run(7);
        chk("zero_stat_at", stat_at, 1);
        chk("zero_beats",   vld_n, 0);
        chk("zero_done_at", done_at, 5);
        chk("zero_cnt",     o_stream_cnt, 0);

        // Abort at cycle 4 of N=8, then a normal N=2 job started at cycle 6
        clr_log();
        cycle(1, 8, 0, 1);
        idle_run(3);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 0, 1);
        chk("abort_done",  done_at, -1);
        chk("abort_cnt",   o_stream_cnt, 2);
        chk("abort_beats", vld_n, 2);
        cycle(1, 2, 0, 1);
        idle_run(9);
        chk("post_abort_done_at", done_at, 13);
        chk("post_abort_cnt",     o_stream_cnt, 2);

        // Async reset during cycle 3 of an N=8 job, start held high throughout
        clr_log();
        cycle(1, 8, 0, 1);
        cycle(1, 8, 0, 1);
        cycle(1, 8, 0, 1);
        i_start = 1; i_num_stream = CW'(8); i_abort = 0; i_fetch_ready = 1;
        #2 rst = 1'b1;
        #1;
        chk("arst_fetch", o_fetch, 0);
        chk("arst_valid", o_mult_valid, 0);
        chk("arst_stat",  o_mult_stationary, 0);
        chk("arst_busy",  o_busy, 0);
        chk("arst_done",  o_done, 0);
        chk("arst_cnt",   o_stream_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        clr_log();
        cycle(1, 3, 0, 1);
        idle_run(9);
        chk("rearm_stat_at", stat_at, 1);
        chk("rearm_done_at", done_at, 8);
        chk("rearm_cnt",     o_stream_cnt, 3);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s, ab, rd;
            int n;
            s  = ($urandom_range(0, 3) == 0);
            n  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 29) == 0);
            rd = ($urandom_range(0, 3) != 0);
            cycle(s, n, ab, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
